pp_transpose_pipe: RTL and testbench
====================================

// Module: pp_transpose_pipe
// PURPOSE
//  Parametrised, pipelined successor of the partial-product column switch. Accepts NUM_PP
//  partial products of PP_WIDTH bits plus a NUM_PP-bit carry bus. Transposes them into
//  PP_WIDTH columns of NUM_PP bits for the compressor tree. Adds a valid/ready handshake,
//  a 2-entry skid buffer, a synchronous flush and an occupancy report.
// PARAMETERS
//  NUM_PP    16  number of partial products (column height), >=2
//  PP_WIDTH  64  partial-product width (number of columns), >=2
// PORTS
//  clk        in   1                  single clock, rising edge
//  rst_n      in   1                  asynchronous, active-low reset
//  flush      in   1                  synchronous discard of all buffered data
//  in_valid   in   1                  input beat valid
//  in_ready   out  1                  skid buffer can accept a beat
//  in_pp      in   NUM_PP*PP_WIDTH    pp i = in_pp[i*PP_WIDTH +: PP_WIDTH]
//  in_cin     in   NUM_PP             carry bus, travels with its beat
//  out_valid  out  1                  output beat valid
//  out_ready  in   1                  downstream accepts the beat
//  out_col    out  PP_WIDTH*NUM_PP    column j = out_col[j*NUM_PP +: NUM_PP]
//  out_cout   out  NUM_PP             in_cin of the presented beat, unmodified
//  occupancy  out  2                  buffered beats: 0, 1 or 2
// BEHAVIOUR
//  - Mapping: out_col[j*NUM_PP + (NUM_PP-1-i)] = pp i bit j.
//    pp 0 lands at the MSB of each column and pp NUM_PP-1 at the LSB.
//  - Handshakes:
//    - push = in_valid & in_ready; pop = out_valid & out_ready.
//    - in_valid must not depend on in_ready; out_valid must not depend on out_ready.
//  - Storage: main register (drives outputs) and skid register.
//    - Transposition happens before the main/skid write.
//    - No combinational path from any input to any output.
//  - FSM states are EMPTY/ONE/TWO; occupancy = 0/1/2; out_valid = (state != EMPTY).
//    - EMPTY + push -> ONE: beat goes to main. Latency from accept to out_valid is 1 cycle.
//    - ONE + push & pop -> ONE: main is reloaded (full throughput, 1 beat/cycle).
//    - ONE + push only -> TWO: beat goes to skid. ONE + pop only -> EMPTY.
//    - TWO + pop -> ONE: skid moves to main.
//    - No push is possible in TWO.
//    - Order is strictly FIFO.
//  - in_ready is a register: 1 in EMPTY/ONE and 0 in TWO. After a pop from TWO it is 1
//    on the next cycle.
//  - Stability: while out_valid=1 and out_ready=0, out_col and out_cout hold stable.
//  - flush: next state is EMPTY and occupancy 0.
//    - Any same-cycle push or pop is discarded and not counted.
//    - Flush has priority over all other events.
//  - Reset (asynchronous assert, mid-beat too): state EMPTY, out_valid=0, in_ready=0,
//    out_col=0, out_cout=0, occupancy=0.
//    in_ready rises 1 cycle after rst_n deasserts.
//  - Data registers load only on push or move. No data-dependent gating, no arithmetic.
// CONFIGURATION
//  - PP_TRANSPOSE_PARITY_EN defined:
//    - Extra output out_par, PP_WIDTH bits; out_par[j] = ^column j.
//    - Computed at input and registered with its beat; same timing and stability as out_col.
//    - Resets to 0.
//  - Not defined: port out_par and its logic are absent. All other behaviour is identical.
// STRUCTURE
//  - Package pp_transpose_pkg holds:
//    - localparams DEF_NUM_PP=16 and DEF_PP_WIDTH=64
//    - enum skid_state_e {EMPTY, ONE, TWO}
//    - occupancy width constant OCC_W=2
//  - Sub-module pp_col_transpose (purely combinational, NUM_PP/PP_WIDTH params) holds the
//    generate-loop bit mapping and, under the macro, the column parity.
//  - Top level pp_transpose_pipe holds the FSM, main/skid registers and handshake.
// TESTING
//  1. Parameters 16x64, out_ready=1. Send pp i = 64'h1 << i, cin=16'hA5A5.
//     Expect next cycle: column i = 16'h8000 >> i, other columns 0, out_cout=16'hA5A5,
//     occupancy=1.
//  2. out_ready=0, push beats A then B. Expect in_ready=0 and occupancy=2.
//     Output holds A. Raise out_ready: A, then B on consecutive cycles; in_ready=1 one
//     cycle after the first pop.
//  3. Continuous in_valid with out_ready=1 for 100 random beats.
//     Expect 100 outputs in order, 1 beat/cycle, each matching the scoreboard transpose.
//  4. Occupancy=2, then flush with in_valid=1 in the same cycle.
//     Expect next cycle: out_valid=0, occupancy=0, the flushed beat never appears.
//  5. Assert rst_n=0 while occupancy=1 and out_ready=0.
//     Expect all outputs 0 immediately; after release, in_ready=1 one cycle later.
//  6. Parity macro, parameters 4x8: pp = 8'hFF, 8'h0F, 8'h00, 8'h01.
//     Expect out_par = 8'hF1 and column 0 = 4'b1101.

Source files
------------

// File: rtl/pp_transpose_pkg.sv
// Package: pp_transpose_pkg
// Shared constants and types for the partial-product transpose pipeline.
//   DEF_NUM_PP / DEF_PP_WIDTH : default column height / column count
//   OCC_W                     : width of the occupancy report
//   skid_state_e              : EMPTY/ONE/TWO buffered-beat state
package pp_transpose_pkg;

  localparam int unsigned DEF_NUM_PP   = 16;
  localparam int unsigned DEF_PP_WIDTH = 64;
  localparam int unsigned OCC_W        = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pp_col_transpose.sv
// Module: pp_col_transpose
// Purely combinational transpose of NUM_PP partial products into PP_WIDTH
// columns. pp 0 lands at the MSB of every column, pp NUM_PP-1 at the LSB.
// Optional feature macro: PP_TRANSPOSE_PARITY_EN (adds per-column parity).
// Ports:
//   i_pp   in   NUM_PP*PP_WIDTH  pp i = i_pp[i*PP_WIDTH +: PP_WIDTH]
//   o_col  out  PP_WIDTH*NUM_PP  column j = o_col[j*NUM_PP +: NUM_PP]
//   o_par  out  PP_WIDTH         (macro only) o_par[j] = ^column j
module pp_col_transpose
  import pp_transpose_pkg::*;
#(
  parameter int unsigned NUM_PP   = DEF_NUM_PP,
  parameter int unsigned PP_WIDTH = DEF_PP_WIDTH
) (
  input  logic [NUM_PP*PP_WIDTH-1:0] i_pp,
`ifdef PP_TRANSPOSE_PARITY_EN
  output logic [PP_WIDTH-1:0]        o_par,
`endif
  output logic [PP_WIDTH*NUM_PP-1:0] o_col
);

  for (genvar j = 0; j < PP_WIDTH; j++) begin : g_col
    for (genvar i = 0; i < NUM_PP; i++) begin : g_row
      assign o_col[j*NUM_PP + (NUM_PP-1-i)] = i_pp[i*PP_WIDTH + j];
    end
`ifdef PP_TRANSPOSE_PARITY_EN
    assign o_par[j] = ^o_col[j*NUM_PP +: NUM_PP];
`endif
  end

endmodule

// File: rtl/pp_transpose_pipe.sv
// Module: pp_transpose_pipe
// Pipelined partial-product transpose with valid/ready handshake, 2-entry
// skid buffer (main + skid register), synchronous flush and occupancy report.
// Optional feature macro: PP_TRANSPOSE_PARITY_EN (adds out_par).
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   flush                 synchronous discard of all buffered beats
//   in_valid / in_ready   input handshake (in_ready is registered)
//   in_pp, in_cin         NUM_PP partial products and their carry bus
//   out_valid / out_ready output handshake
//   out_col, out_cout     transposed columns and carry bus of presented beat
//   out_par               (macro only) per-column parity of presented beat
//   occupancy             buffered beats: 0, 1 or 2
module pp_transpose_pipe
  import pp_transpose_pkg::*;
#(
  parameter int unsigned NUM_PP   = DEF_NUM_PP,
  parameter int unsigned PP_WIDTH = DEF_PP_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_PP*PP_WIDTH-1:0] in_pp,
  input  logic [NUM_PP-1:0]          in_cin,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PP_WIDTH*NUM_PP-1:0] out_col,
  output logic [NUM_PP-1:0]          out_cout,
`ifdef PP_TRANSPOSE_PARITY_EN
  output logic [PP_WIDTH-1:0]        out_par,
`endif
  output logic [OCC_W-1:0]           occupancy
);

  localparam int unsigned COL_W = PP_WIDTH*NUM_PP;
`ifdef PP_TRANSPOSE_PARITY_EN
  localparam int unsigned BEAT_W = COL_W + NUM_PP + PP_WIDTH;
`else
  localparam int unsigned BEAT_W = COL_W + NUM_PP;
`endif

  logic [COL_W-1:0]  w_col;
  logic [BEAT_W-1:0] w_beat;
  logic              w_push;
  logic              w_pop;

  skid_state_e       r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [OCC_W-1:0]  r_occ;
  logic [BEAT_W-1:0] r_main;
  logic [BEAT_W-1:0] r_skid;

  // Beat layout, LSB first: columns, carry bus, then parity when enabled.
`ifdef PP_TRANSPOSE_PARITY_EN
  logic [PP_WIDTH-1:0] w_par;

  pp_col_transpose #(.NUM_PP(NUM_PP), .PP_WIDTH(PP_WIDTH)) u_xpose (
    .i_pp  (in_pp),
    .o_par (w_par),
    .o_col (w_col)
  );

  assign w_beat  = {w_par, in_cin, w_col};
  assign out_par = r_main[COL_W+NUM_PP +: PP_WIDTH];
`else
  pp_col_transpose #(.NUM_PP(NUM_PP), .PP_WIDTH(PP_WIDTH)) u_xpose (
    .i_pp  (in_pp),
    .o_col (w_col)
  );

  assign w_beat = {in_cin, w_col};
`endif

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = r_out_valid & out_ready;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign occupancy = r_occ;
  assign out_col   = r_main[COL_W-1:0];
  assign out_cout  = r_main[COL_W +: NUM_PP];

  // Flow-control outputs are registered alongside the state so nothing
  // at an output depends combinationally on an input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_occ       <= '0;
      r_main      <= '0;
      r_skid      <= '0;
    end else if (flush) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_occ       <= '0;
    end else begin
      unique case (r_state)
        EMPTY: begin
          // Also the path that raises in_ready on the first edge after reset.
          r_in_ready <= 1'b1;
          if (w_push) begin
            r_main      <= w_beat;
            r_state     <= ONE;
            r_out_valid <= 1'b1;
            r_occ       <= OCC_W'(1);
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            r_main <= w_beat;
          end else if (w_push) begin
            r_skid     <= w_beat;
            r_state    <= TWO;
            r_in_ready <= 1'b0;
            r_occ      <= OCC_W'(2);
          end else if (w_pop) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_occ       <= '0;
          end
        end
        TWO: begin
          if (w_pop) begin
            r_main     <= r_skid;
            r_state    <= ONE;
            r_in_ready <= 1'b1;
            r_occ      <= OCC_W'(1);
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_occ       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pp_transpose_pipe.sv
// Testbench for pp_transpose_pipe: a 16x64 instance driven by hand sequences,
// a control vector table and a random stream, plus a 4x8 instance for the
// small-geometry mapping (and parity when PP_TRANSPOSE_PARITY_EN is defined).
module tb_pp_transpose_pipe;

  localparam int unsigned NP = 16;
  localparam int unsigned PW = 64;
  localparam int unsigned CW = NP*PW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_pp;
  logic [NP-1:0] in_cin;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_col;
  logic [NP-1:0] out_cout;
  logic [1:0]    occupancy;

  logic        s_flush, s_valid, s_ready, s_ovalid, s_oready;
  logic [31:0] s_pp, s_col;
  logic [3:0]  s_cin, s_cout;
  logic [1:0]  s_occ;

`ifdef PP_TRANSPOSE_PARITY_EN
  logic [PW-1:0] out_par;
  logic [7:0]    s_par;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pp_transpose_pipe #(.NUM_PP(NP), .PP_WIDTH(PW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pp     (in_pp),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .out_cout  (out_cout),
`ifdef PP_TRANSPOSE_PARITY_EN
    .out_par   (out_par),
`endif
    .occupancy (occupancy)
  );

  pp_transpose_pipe #(.NUM_PP(4), .PP_WIDTH(8)) dut_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (s_flush),
    .in_valid  (s_valid),
    .in_ready  (s_ready),
    .in_pp     (s_pp),
    .in_cin    (s_cin),
    .out_valid (s_ovalid),
    .out_ready (s_oready),
    .out_col   (s_col),
    .out_cout  (s_cout),
`ifdef PP_TRANSPOSE_PARITY_EN
    .out_par   (s_par),
`endif
    .occupancy (s_occ)
  );

  typedef struct {
    logic        flush;
    logic        vld;
    logic        ordy;
    int unsigned tag;
    logic        e_ov;
    logic        e_ir;
    logic [1:0]  e_occ;
    int unsigned e_tag;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_cols(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    int unsigned bad;
    checks++;
    if (act !== exp) begin
      errors++;
      bad = 0;
      for (int unsigned j = PW; j > 0; j--)
        if (act[(j-1)*NP +: NP] !== exp[(j-1)*NP +: NP]) bad = j - 1;
      $display("FAIL %s: column %0d got %h expected %h", name, bad,
               act[bad*NP +: NP], exp[bad*NP +: NP]);
    end
  endtask

  // Reference transpose walks the output bits and looks up their source.
  function automatic logic [CW-1:0] model_tr(input logic [CW-1:0] pp);
    logic [CW-1:0] c;
    for (int unsigned k = 0; k < CW; k++)
      c[k] = pp[(NP-1-(k % NP))*PW + (k / NP)];
    return c;
  endfunction

  function automatic logic [CW-1:0] make_pp(input int unsigned tag);
    logic [CW-1:0] r;
    logic [31:0]   hi, lo;
    for (int unsigned i = 0; i < NP; i++) begin
      hi = (tag * 32'h9E3779B9) ^ i;
      lo = tag + i * 32'h01010101;
      r[i*PW +: PW] = {hi, lo};
    end
    return r;
  endfunction

  function automatic logic [NP-1:0] make_cin(input int unsigned tag);
    logic [31:0] t;
    t = tag * 32'h1357;
    return t[15:0] ^ 16'hBEEF;
  endfunction

  initial begin
    logic [CW-1:0] exp_col;
    logic [CW-1:0] beat;
    logic [NP-1:0] cin;

    // flush vld ordy tag | ov ir occ out_tag
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1,  1'b1, 1'b1, 2'd1, 1};   // A accepted
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 2,  1'b1, 1'b0, 2'd2, 1};   // B to skid
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 3,  1'b1, 1'b0, 2'd2, 1};   // blocked, A held
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 0,  1'b1, 1'b1, 2'd1, 2};   // pop A, B shown
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 0,  1'b0, 1'b1, 2'd0, 0};   // pop B
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 4,  1'b1, 1'b1, 2'd1, 4};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 5,  1'b1, 1'b0, 2'd2, 4};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 6,  1'b0, 1'b1, 2'd0, 0};   // flush in TWO
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 0,  1'b0, 1'b1, 2'd0, 0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 7,  1'b1, 1'b1, 2'd1, 7};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 8,  1'b0, 1'b1, 2'd0, 0};   // flush beats push+pop
    vecs[11] = '{1'b0, 1'b1, 1'b1, 9,  1'b1, 1'b1, 2'd1, 9};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 10, 1'b1, 1'b1, 2'd1, 10};  // push+pop reload
    vecs[13] = '{1'b0, 1'b0, 1'b0, 0,  1'b1, 1'b1, 2'd1, 10};  // stall, stable
    vecs[14] = '{1'b0, 1'b0, 1'b0, 0,  1'b1, 1'b1, 2'd1, 10};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 11, 1'b1, 1'b1, 2'd1, 11};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 0,  1'b0, 1'b1, 2'd0, 0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pp = '0; in_cin = '0;
    s_flush = 1'b0; s_valid = 1'b0; s_oready = 1'b0; s_pp = '0; s_cin = '0;

    // Reset state
    #1;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd0);
    chk("reset occupancy", 64'(occupancy), 64'd0);
    chk_cols("reset out_col", out_col, '0);
    chk("reset out_cout", 64'(out_cout), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 chk("in_ready before first edge", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("in_ready after release", 64'(in_ready), 64'd1);

    // 4x8 geometry
    s_pp = {8'h01, 8'h00, 8'h0F, 8'hFF};
    s_cin = 4'h9; s_valid = 1'b1; s_oready = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    chk("small out_valid", 64'(s_ovalid), 64'd1);
    chk("small column 0", 64'(s_col[3:0]), 64'hD);
    chk("small out_col", 64'(s_col), 64'h8888CCCD);
    chk("small out_cout", 64'(s_cout), 64'h9);
`ifdef PP_TRANSPOSE_PARITY_EN
    chk("small out_par", 64'(s_par), 64'hF1);
`endif

    // Walking-one partial products
    for (int unsigned i = 0; i < NP; i++) in_pp[i*PW +: PW] = 64'h1 << i;
    in_cin = 16'hA5A5; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_col = '0;
    for (int unsigned i = 0; i < NP; i++) exp_col[i*NP +: NP] = 16'h8000 >> i;
    chk("walk out_valid", 64'(out_valid), 64'd1);
    chk_cols("walk out_col", out_col, exp_col);
    chk("walk out_cout", 64'(out_cout), 64'hA5A5);
    chk("walk occupancy", 64'(occupancy), 64'd1);
`ifdef PP_TRANSPOSE_PARITY_EN
    chk("walk out_par", out_par, 64'h0000_0000_0000_FFFF);
`endif
    @(posedge clk); #1;
    chk("walk drained", 64'(out_valid), 64'd0);

    // Control vector table
    for (int v = 0; v < 17; v++) begin
      flush = vecs[v].flush; in_valid = vecs[v].vld; out_ready = vecs[v].ordy;
      in_pp = make_pp(vecs[v].tag); in_cin = make_cin(vecs[v].tag);
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_valid", v), 64'(out_valid), 64'(vecs[v].e_ov));
      chk($sformatf("vec%0d in_ready", v), 64'(in_ready), 64'(vecs[v].e_ir));
      chk($sformatf("vec%0d occupancy", v), 64'(occupancy), 64'(vecs[v].e_occ));
      if (vecs[v].e_ov) begin
        chk_cols($sformatf("vec%0d out_col", v), out_col, model_tr(make_pp(vecs[v].e_tag)));
        chk($sformatf("vec%0d out_cout", v), 64'(out_cout), 64'(make_cin(vecs[v].e_tag)));
      end
    end
    flush = 1'b0; in_valid = 1'b0;

    // Random streaming at full throughput
    out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      for (int unsigned w = 0; w < CW/32; w++) beat[w*32 +: 32] = $urandom;
      cin = 16'($urandom);
      in_pp = beat; in_cin = cin; in_valid = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("stream%0d out_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("stream%0d in_ready", k), 64'(in_ready), 64'd1);
      chk_cols($sformatf("stream%0d out_col", k), out_col, model_tr(beat));
      chk($sformatf("stream%0d out_cout", k), 64'(out_cout), 64'(cin));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("stream drained", 64'(out_valid), 64'd0);

    // Asynchronous reset while holding a beat
    out_ready = 1'b0; in_pp = make_pp(21); in_cin = make_cin(21); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre-reset occupancy", 64'(occupancy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async out_valid", 64'(out_valid), 64'd0);
    chk("async in_ready", 64'(in_ready), 64'd0);
    chk("async occupancy", 64'(occupancy), 64'd0);
    chk_cols("async out_col", out_col, '0);
    chk("async out_cout", 64'(out_cout), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 chk("post-reset in_ready low", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("post-reset in_ready high", 64'(in_ready), 64'd1);
    chk("post-reset out_valid", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
